// File: rtl/demux_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_scan_ctrl_pkg
//  Description : Shared definitions for the demux scan controller: FSM state
//                encoding, default select width, output count and dwell
//                counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_scan_ctrl_pkg;

  // Default select width and resulting demux output count
  localparam int SEL_W_DEF = 5;
  localparam int N_OUT     = 32;

  // Dwell counter width; covers DWELL up to 256 (terminal value 255)
  localparam int CNT_W     = 8;

  // Scan controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage : demux_scan_ctrl_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Counts clock cycles spent on one select value. Raises tc
//                while the count sits at DWELL-1 and wraps to zero on the
//                next enabled cycle. clr forces the count back to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
  import demux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int WIDTH = CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(DWELL - 1);

  logic [WIDTH-1:0] count;

  // Terminal count is decoded straight from the registered count
  assign tc = (count == TC_VAL);

  // Dwell counter: clear wins, otherwise advance and wrap at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : demux_scan_ctrl
//  Description : Scans a select value across every output of a downstream
//                1-to-2**SEL_W demux, holding each value for DWELL cycles.
//                Supports single or continuous scans, hold and abort.
//                sel and dem_in connect directly to the demux.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_scan_ctrl
  import demux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4,          // cycles per select value, 1..256
  parameter int SEL_W = SEL_W_DEF   // select width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             hold,
  input  logic             stop,
  output logic [SEL_W-1:0] sel,
  output logic             dem_in,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  scan_state_e state;
  logic        cont_q;   // scan mode captured at start
  logic        dw_en;
  logic        dw_clr;
  logic        dw_tc;

  // Dwell advances only while actively scanning and not frozen or aborted;
  // outside RUN, or on abort, the count is forced back to zero.
  assign dw_en  = (state == ST_RUN) && !hold && !stop;
  assign dw_clr = (state != ST_RUN) || stop;

  dwell_timer #(
    .DWELL (DWELL),
    .WIDTH (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dw_en),
    .clr   (dw_clr),
    .tc    (dw_tc)
  );

  // Scan FSM with registered outputs; done/wrap default low for 1-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cont_q <= 1'b0;
      sel    <= '0;
      dem_in <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state  <= ST_RUN;
            cont_q <= cont;
            sel    <= '0;
            dem_in <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Abort outranks hold and end-of-scan; no done pulse
            state  <= ST_IDLE;
            sel    <= '0;
            dem_in <= 1'b0;
            busy   <= 1'b0;
          end else if (!hold && dw_tc) begin
            if (&sel) begin
              if (cont_q) begin
                sel  <= '0;
                wrap <= 1'b1;
              end else begin
                state  <= ST_DONE;
                sel    <= '0;
                dem_in <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Single-cycle completion state; start is not looked at here
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          sel    <= '0;
          dem_in <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule : demux_scan_ctrl
`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_scan_ctrl
//  Description : Self-checking bench for demux_scan_ctrl. Two instances
//                (DWELL=4 and DWELL=1) share stimulus; a cycle-level model
//                tracks elapsed scan cycles and derives sel arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_scan_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cont  = 1'b0;
  logic hold  = 1'b0;
  logic stop  = 1'b0;

  always #5 clk = ~clk;

  logic [4:0] sel_o  [2];
  logic       dem_o  [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       wrap_o [2];

  demux_scan_ctrl #(.DWELL(4), .SEL_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .hold(hold), .stop(stop),
    .sel(sel_o[0]), .dem_in(dem_o[0]), .busy(busy_o[0]), .done(done_o[0]), .wrap(wrap_o[0])
  );

  demux_scan_ctrl #(.DWELL(1), .SEL_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .hold(hold), .stop(stop),
    .sel(sel_o[1]), .dem_in(dem_o[1]), .busy(busy_o[1]), .done(done_o[1]), .wrap(wrap_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic int dwell_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: active flag plus count of unfrozen scan cycles since start
  bit m_act  [2];
  int m_adv  [2];
  bit m_cont [2];
  bit m_done [2];
  bit m_wrap [2];
  bit m_dst  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_adv[i] <= 0; m_cont[i] <= 1'b0;
        m_done[i] <= 1'b0; m_wrap[i] <= 1'b0; m_dst[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int a   = m_adv[i];
        automatic bit act = m_act[i];
        automatic bit dn  = 1'b0;
        automatic bit wr  = 1'b0;
        automatic bit dst = 1'b0;
        if (m_dst[i]) begin
          act = 1'b0;
        end else if (!act) begin
          if (start && !stop) begin
            act = 1'b1;
            a   = 0;
            m_cont[i] <= cont;
          end
        end else if (stop) begin
          act = 1'b0;
        end else if (!hold) begin
          a++;
          if (a == 32 * dwell_of(i)) begin
            a = 0;
            if (m_cont[i]) wr = 1'b1;
            else begin act = 1'b0; dn = 1'b1; dst = 1'b1; end
          end
        end
        m_act[i] <= act; m_adv[i] <= a; m_done[i] <= dn; m_wrap[i] <= wr; m_dst[i] <= dst;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic logic [4:0]  es = m_act[i] ? 5'((m_adv[i] / dwell_of(i)) % 32) : 5'd0;
      automatic logic [31:0] ey = m_act[i] ? (32'd1 << es) : 32'd0;
      automatic logic [31:0] ay = dem_o[i] ? (32'd1 << sel_o[i]) : 32'd0;
      check($sformatf("sel%0d", i),  32'(sel_o[i]),  32'(es));
      check($sformatf("dem%0d", i),  32'(dem_o[i]),  32'(m_act[i]));
      check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_act[i]));
      check($sformatf("done%0d", i), 32'(done_o[i]), 32'(m_done[i]));
      check($sformatf("wrap%0d", i), 32'(wrap_o[i]), 32'(m_wrap[i]));
      check($sformatf("demux_y%0d", i), ay, ey);
    end
  end

  // Wait for an event on instance 0: 0=done, 1=wrap, 2=sel==val
  task automatic wait_ev(input int what, input int val, output int t);
    t = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if ((what == 0 && done_o[0]) || (what == 1 && wrap_o[0]) ||
          (what == 2 && int'(sel_o[0]) == val)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check($sformatf("timeout_ev%0d", what), 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic c, output int t0);
    @(negedge clk);
    start = 1'b1; cont = c;
    @(negedge clk);
    t0 = cyc;
    start = 1'b0; cont = 1'b0;
  endtask

  initial begin
    int t0, t;
    repeat (3) @(negedge clk);
    check("reset_sel",  32'(sel_o[0]),  32'd0);
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    rst_n = 1'b1;

    // Single scan: done 128 cycles after the start edge
    do_start(1'b0, t0);
    check("start_busy", 32'(busy_o[0]), 32'd1);
    wait_ev(0, 0, t);
    check("single_done_cycle", 32'(t - t0), 32'd128);
    @(negedge clk);
    check("after_done_busy", 32'(busy_o[0]), 32'd0);
    repeat (2) @(negedge clk);

    // Start and cont toggling mid-scan have no effect
    do_start(1'b0, t0);
    wait_ev(2, 10, t);
    start = 1'b1; cont = 1'b1;
    @(negedge clk);
    start = 1'b0; cont = 1'b0;
    wait_ev(0, 0, t);
    check("restart_ignored_done", 32'(t - t0), 32'd128);
    repeat (2) @(negedge clk);

    // Hold 10 cycles at sel=5 delays end by 10
    do_start(1'b0, t0);
    wait_ev(2, 5, t);
    hold = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_sel", 32'(sel_o[0]), 32'd5);
    hold = 1'b0;
    wait_ev(0, 0, t);
    check("hold_done_cycle", 32'(t - t0), 32'd138);
    repeat (2) @(negedge clk);

    // Continuous: wraps at 128 and 256, then abort
    do_start(1'b1, t0);
    wait_ev(1, 0, t);
    check("wrap1_cycle", 32'(t - t0), 32'd128);
    check("wrap1_sel",   32'(sel_o[0]), 32'd0);
    check("wrap1_busy",  32'(busy_o[0]), 32'd1);
    wait_ev(1, 0, t);
    check("wrap2_cycle", 32'(t - t0), 32'd256);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", 32'(busy_o[0]), 32'd0);
    check("stop_done", 32'(done_o[0]), 32'd0);
    repeat (2) @(negedge clk);

    // Start together with stop in IDLE is refused
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", 32'(busy_o[0]), 32'd0);

    // Asynchronous reset mid-scan, then immediate restart
    do_start(1'b0, t0);
    wait_ev(2, 17, t);
    #2 rst_n = 1'b0;
    #1;
    check("async_sel",  32'(sel_o[0]),  32'd0);
    check("async_dem",  32'(dem_o[0]),  32'd0);
    check("async_busy", 32'(busy_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_reset_start", 32'(busy_o[0]), 32'd1);

    // Randomized traffic against the model
    repeat (4000) begin
      @(negedge clk);
      start = ($urandom % 8) == 0;
      cont  = $urandom % 2;
      hold  = ($urandom % 8) == 0;
      stop  = ($urandom % 64) == 0;
    end
    start = 1'b0; cont = 1'b0; hold = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux_scan_ctrl
`default_nettype wire
